gmii_tx_framer: RTL and testbench
=================================

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 The block SHALL have parameter MIN_FRAME_BYTES, default 60, meaning the minimum count of payload plus pad bytes before the FCS; the value 0 SHALL disable padding.
REQ-002 The block SHALL have the port Clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have the port Rst, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have the port Input_data, input, 8 bits, the payload byte.
REQ-005 The block SHALL have the port Input_valid, input, 1 bit, which marks the payload byte as valid.
REQ-006 The block SHALL have the port Input_last, input, 1 bit, which marks the final payload byte of a frame.
REQ-007 The block SHALL have the port Input_ready, output, 1 bit; a payload byte is accepted when Input_valid and Input_ready are both high.
REQ-008 The block SHALL have the port Output_data, output, 8 bits, the framed byte going to a gmii_arb input.
REQ-009 The block SHALL have the port Output_valid, output, 1 bit, which marks the framed byte as valid.
REQ-010 The block SHALL have the port Output_last, output, 1 bit, which marks the final FCS byte.
REQ-011 The block SHALL have the port Output_ready, input, 1 bit, which is the arbiter ready.

Function
REQ-012 The output handshake SHALL work as follows:
- Output_data, Output_valid and Output_last are registers.
- A byte transfers when Output_valid and Output_ready are both high.
- The registers load a new byte only when Output_valid is low or Output_ready is high; otherwise they hold their values.
REQ-013 Input_ready SHALL equal (state==PAYLOAD) && (!Output_valid || Output_ready).
REQ-014 The state machine SHALL have the states IDLE, PREAMBLE, PAYLOAD, PAD and FCS.
REQ-015 In IDLE, when Input_valid is high, the next state SHALL be PREAMBLE, or PAYLOAD if the preamble is compiled out; no byte is consumed in this cycle.
REQ-016 PREAMBLE SHALL emit 7 bytes of 0x55 followed by 0xD5, then go to PAYLOAD.
REQ-017 PAYLOAD SHALL forward each accepted byte with a one-cycle register latency.
REQ-018 On the accepted byte with Input_last high, the next state SHALL be PAD if the byte count after that byte is below MIN_FRAME_BYTES; otherwise it SHALL be FCS.
REQ-019 PAD SHALL emit 0x00 bytes until the byte count equals MIN_FRAME_BYTES, then go to FCS.
REQ-020 FCS SHALL emit 4 bytes, the complement of CRC-32 (polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF), least-significant byte first.
REQ-021 Output_last SHALL be high on the 4th FCS byte only; when that byte transfers, the next state SHALL be IDLE.
REQ-022 The CRC SHALL cover payload and pad bytes only, never the preamble or SFD.
REQ-023 The byte counter SHALL have width $clog2(MIN_FRAME_BYTES+1) and saturate at MIN_FRAME_BYTES; it SHALL clear in IDLE.
REQ-024 A 1-byte payload (Input_last on the first byte) SHALL be legal and SHALL be padded.
REQ-025 When Output_ready is held low, no state, counter or CRC SHALL advance, and Output_* SHALL hold their values.
REQ-026 Input_valid low during PAYLOAD SHALL insert output bubbles (Output_valid low); the frame SHALL NOT be aborted.
REQ-027 A new frame SHALL NOT start until the FCS of the previous frame has fully transferred; the block adds no interframe gap.

Reset
REQ-028 While Rst is high:
- Output_valid, Output_last and Input_ready are 0.
- Output_data is 0x00.
- The state is IDLE.
- The counter is 0.
- The CRC is 0xFFFFFFFF.
REQ-029 Reset mid-frame SHALL discard the partial frame; after release the block SHALL wait for a new Input_valid in IDLE.

Configuration
REQ-030 With GMII_TX_FRAMER_PREAMBLE_EN defined, the block SHALL emit the 8-byte preamble/SFD before every frame.
REQ-031 Without GMII_TX_FRAMER_PREAMBLE_EN, IDLE SHALL go directly to PAYLOAD, and the frame SHALL start with the first payload byte.

Structure
REQ-032 eth_pkg SHALL hold:
- the state enum;
- the preamble byte (0x55) and SFD byte (0xD5) constants;
- the CRC-32 polynomial and init constants;
- the FCS length (4).
REQ-033 The byte-wide CRC update SHALL be the sub-module eth_crc32, with ports Clk, Rst, Clear, Data_valid, Data[7:0] and Crc_out[31:0].

Verification
REQ-034 Test 1: preamble compiled in, MIN_FRAME_BYTES=60, 1-byte payload 0x00, with:
- Output_ready held high: the output SHALL be 72 bytes (8 preamble, 0x00, 59×0x00, 4 FCS), with Output_last on byte 72.
- Output_ready toggled at random: the result SHALL match the held-high case.
REQ-035 Test 2: MIN_FRAME_BYTES=0, preamble compiled out, payload "123456789" (0x31..0x39): the output SHALL be the 9 bytes followed by 0x26 0x39 0xF4 0xCB.
REQ-036 Test 3: MIN_FRAME_BYTES=60, 60-byte random payload: there SHALL be no pad bytes, and the FCS SHALL match the reference-model CRC.
REQ-037 Test 4: Output_ready held low for 20 cycles mid-payload: Input_ready SHALL be 0, Output_data SHALL be stable, and no byte SHALL be lost or duplicated.
REQ-038 Test 5: Rst asserted for 2 cycles at payload byte 5: all outputs SHALL be 0; the next frame SHALL be complete and correct.
REQ-039 Test 6: 200 back-to-back random frames (1–200 bytes) with Input_valid gaps, feeding a gmii_arb model: every frame SHALL be received intact, in order, with a correct FCS.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions.
// Contents: framer state enum, preamble/SFD bytes, CRC-32 constants and a
// byte-wide reflected CRC-32 update function.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    PAD,
    FCS
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam int unsigned FCS_LEN       = 4;

  // Bit-reverse a 32-bit word (normal polynomial -> reflected form).
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // One byte of reflected CRC-32, LSB of the data byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ reflect32(CRC32_POLY)) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide running CRC-32 register (reflected, init all ones).
// Ports: Clk, Rst (async active-high), Clear (sync re-init), Data_valid,
//        Data[7:0] byte to fold in, Crc_out[31:0] raw register (not inverted).
module eth_crc32
  import eth_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Clear,
  input  logic        Data_valid,
  input  logic [7:0]  Data,
  output logic [31:0] Crc_out
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Crc_out <= CRC32_INIT;
    end else if (Clear) begin
      Crc_out <= CRC32_INIT;
    end else if (Data_valid) begin
      Crc_out <= crc32_byte(Crc_out, Data);
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: optional preamble/SFD, payload forwarding, zero pad
// up to MIN_FRAME_BYTES and a 4-byte FCS, with a registered ready/valid output.
// Ports: Clk, Rst (async active-high); Input_data/valid/last/ready payload
//        stream in; Output_data/valid/last/ready framed stream out.
// Build option: define GMII_TX_FRAMER_PREAMBLE_EN to emit 7x0x55 + 0xD5
//        before every frame; otherwise frames start with the first payload byte.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned MIN_FRAME_BYTES = 60
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Input_data,
  input  logic       Input_valid,
  input  logic       Input_last,
  output logic       Input_ready,
  output logic [7:0] Output_data,
  output logic       Output_valid,
  output logic       Output_last,
  input  logic       Output_ready
);

  // Counter is at least 1 bit wide so MIN_FRAME_BYTES=0 still elaborates.
  localparam int unsigned CNT_W = (MIN_FRAME_BYTES > 0) ? $clog2(MIN_FRAME_BYTES + 1) : 1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME_BYTES);

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       fcs_idx;
  logic [31:0]      crc;
  logic [31:0]      crc_n;
  logic [7:0]       fcs_byte;
  logic             advance;
  logic             crc_valid;
  logic             crc_clear;
  logic [7:0]       crc_data;
`ifdef GMII_TX_FRAMER_PREAMBLE_EN
  logic [2:0]       pre_cnt;
`endif

  // Output register may load whenever it is empty or being drained.
  assign advance     = !Output_valid || Output_ready;
  assign Input_ready = (state == PAYLOAD) && advance;

  assign cnt_inc = (byte_cnt < MIN_CNT) ? byte_cnt + CNT_W'(1) : byte_cnt;

  // CRC folds in accepted payload bytes and emitted pad bytes only.
  assign crc_valid = (Input_ready && Input_valid) || ((state == PAD) && advance);
  assign crc_data  = (state == PAD) ? 8'h00 : Input_data;
  assign crc_clear = (state == IDLE);

  assign crc_n    = ~crc;
  assign fcs_byte = crc_n[{fcs_idx[1:0], 3'b000} +: 8];

  eth_crc32 u_crc (
    .Clk       (Clk),
    .Rst       (Rst),
    .Clear     (crc_clear),
    .Data_valid(crc_valid),
    .Data      (crc_data),
    .Crc_out   (crc)
  );

  // Framing FSM with registered output byte; everything stalls while !advance.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      fcs_idx      <= '0;
      Output_data  <= 8'h00;
      Output_valid <= 1'b0;
      Output_last  <= 1'b0;
`ifdef GMII_TX_FRAMER_PREAMBLE_EN
      pre_cnt      <= '0;
`endif
    end else if (advance) begin
      case (state)
        IDLE: begin
          Output_valid <= 1'b0;
          Output_last  <= 1'b0;
          byte_cnt     <= '0;
          fcs_idx      <= '0;
          if (Input_valid) begin
`ifdef GMII_TX_FRAMER_PREAMBLE_EN
            pre_cnt <= '0;
            state   <= PREAMBLE;
`else
            state   <= PAYLOAD;
`endif
          end
        end
        PREAMBLE: begin
`ifdef GMII_TX_FRAMER_PREAMBLE_EN
          Output_valid <= 1'b1;
          Output_data  <= (pre_cnt == 3'(PREAMBLE_LEN)) ? SFD_BYTE : PREAMBLE_BYTE;
          if (pre_cnt == 3'(PREAMBLE_LEN)) begin
            state <= PAYLOAD;
          end else begin
            pre_cnt <= pre_cnt + 3'd1;
          end
`else
          state <= IDLE;
`endif
        end
        PAYLOAD: begin
          // Missing input leaves a bubble rather than aborting the frame.
          Output_valid <= Input_valid;
          if (Input_valid) begin
            Output_data <= Input_data;
            byte_cnt    <= cnt_inc;
            if (Input_last) begin
              state <= (cnt_inc < MIN_CNT) ? PAD : FCS;
            end
          end
        end
        PAD: begin
          Output_valid <= 1'b1;
          Output_data  <= 8'h00;
          byte_cnt     <= cnt_inc;
          if (cnt_inc == MIN_CNT) begin
            state <= FCS;
          end
        end
        FCS: begin
          // fcs_idx == FCS_LEN means the final byte is transferring now.
          if (fcs_idx == 3'(FCS_LEN)) begin
            Output_valid <= 1'b0;
            Output_last  <= 1'b0;
            state        <= IDLE;
          end else begin
            Output_valid <= 1'b1;
            Output_data  <= fcs_byte;
            Output_last  <= (fcs_idx == 3'(FCS_LEN - 1));
            fcs_idx      <= fcs_idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: one instance with MIN_FRAME_BYTES=60 and
// one with MIN_FRAME_BYTES=0, sharing the input stream (selected by sel_b).
module tb_gmii_tx_framer;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic       sel_b;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_last;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_last;
  logic [7:0] a_out_data, b_out_data;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  assign a_in_valid = in_valid & ~sel_b;
  assign b_in_valid = in_valid & sel_b;
  assign in_ready   = sel_b ? b_in_ready  : a_in_ready;
  assign out_valid  = sel_b ? b_out_valid : a_out_valid;
  assign out_last   = sel_b ? b_out_last  : a_out_last;
  assign out_data   = sel_b ? b_out_data  : a_out_data;

  gmii_tx_framer #(.MIN_FRAME_BYTES(60)) u_dut_a (
    .Clk(clk), .Rst(rst),
    .Input_data(in_data), .Input_valid(a_in_valid), .Input_last(in_last), .Input_ready(a_in_ready),
    .Output_data(a_out_data), .Output_valid(a_out_valid), .Output_last(a_out_last),
    .Output_ready(out_ready)
  );

  gmii_tx_framer #(.MIN_FRAME_BYTES(0)) u_dut_b (
    .Clk(clk), .Rst(rst),
    .Input_data(in_data), .Input_valid(b_in_valid), .Input_last(in_last), .Input_ready(b_in_ready),
    .Output_data(b_out_data), .Output_valid(b_out_valid), .Output_last(b_out_last),
    .Output_ready(out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 0;  // 0 held high, 1 random, 2 held low
  int frames_done = 0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sink readiness, updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ($urandom_range(99) < 60);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Arbiter-side model: record every transferred byte with its last flag.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        rx_q.push_back({out_last, out_data});
        if (out_last) frames_done++;
      end
    end
  end

  // Reference FCS value (already complemented).
  function automatic logic [31:0] ref_crc(input byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_preamble();
`ifdef GMII_TX_FRAMER_PREAMBLE_EN
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
`endif
  endtask

  task automatic append_expected(input byte_q_t pay, input int min_bytes);
    byte_q_t body;
    logic [31:0] fcs;
    body = pay;
    while (body.size() < min_bytes) body.push_back(8'h00);
    fcs = ref_crc(body);
    push_preamble();
    foreach (body[i]) exp_q.push_back({1'b0, body[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), fcs[8*k +: 8]});
  endtask

  task automatic compare_stream(input string tag);
    int mism = 0;
    int n;
    check({tag, " len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) mism++;
    check({tag, " bytes"}, mism, 0);
    rx_q.delete();
    exp_q.delete();
    frames_done = 0;
  endtask

  // Called at posedge+1; drives one frame, stopping early after abort_at bytes.
  task automatic send(input byte_q_t pay, input int gap_pct, input int abort_at);
    int i = 0;
    int guard = 0;
    logic acc;
    while (i < pay.size() && guard < 20000) begin
      if (i == abort_at) break;
      if (!in_valid) in_valid = ($urandom_range(99) >= gap_pct);
      in_data = pay[i];
      in_last = (i == pay.size() - 1);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        in_valid = 1'b0;
      end
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (abort_at < 0) check("send accepted", i, pay.size());
  endtask

  task automatic wait_frames(input string tag, input int n);
    int g = 0;
    while (frames_done < n && g < 60000) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, " frames"}, frames_done, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " a valid"}, a_out_valid, 1'b0);
    check({tag, " a last"},  a_out_last,  1'b0);
    check({tag, " a ready"}, a_in_ready,  1'b0);
    check({tag, " a data"},  a_out_data,  8'h00);
    check({tag, " b valid"}, b_out_valid, 1'b0);
    check({tag, " b data"},  b_out_data,  8'h00);
  endtask

  initial begin
    byte_q_t pay;
    byte_q_t frames[$];
    logic [7:0] held;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; sel_b = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Test 1: 1-byte payload, padded to 60, ready high then random.
    pay = {8'h00};
    send(pay, 0, -1);
    wait_frames("t1", 1);
`ifdef GMII_TX_FRAMER_PREAMBLE_EN
    check("t1 total bytes", rx_q.size(), 72);
`else
    check("t1 total bytes", rx_q.size(), 64);
`endif
    if (rx_q.size() > 0) check("t1 last on final", rx_q[rx_q.size()-1][8], 1'b1);
    append_expected(pay, 60);
    compare_stream("t1 ready high");

    ready_mode = 1;
    send(pay, 0, -1);
    wait_frames("t1r", 1);
    append_expected(pay, 60);
    compare_stream("t1 ready random");
    ready_mode = 0;

    // Test 2: "123456789", no padding, known CRC-32 0xCBF43926.
    sel_b = 1'b1;
    @(posedge clk); #1;
    pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send(pay, 0, -1);
    wait_frames("t2", 1);
    push_preamble();
    foreach (pay[i]) exp_q.push_back({1'b0, pay[i]});
    exp_q.push_back({1'b0, 8'h26});
    exp_q.push_back({1'b0, 8'h39});
    exp_q.push_back({1'b0, 8'hF4});
    exp_q.push_back({1'b1, 8'hCB});
    compare_stream("t2 check string");
    sel_b = 1'b0;
    @(posedge clk); #1;

    // Test 3: exactly 60 random bytes, no pad.
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'($urandom_range(255)));
    send(pay, 0, -1);
    wait_frames("t3", 1);
`ifdef GMII_TX_FRAMER_PREAMBLE_EN
    check("t3 total bytes", rx_q.size(), 72);
`else
    check("t3 total bytes", rx_q.size(), 64);
`endif
    append_expected(pay, 60);
    compare_stream("t3 no pad");

    // Test 4: sink stalls mid-payload.
    pay.delete();
    for (int i = 0; i < 40; i++) pay.push_back(8'(i * 7 + 3));
    fork
      send(pay, 0, -1);
      begin
        repeat (20) @(posedge clk);
        ready_mode = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        held = out_data;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          check("t4 stall in_ready", in_ready, 1'b0);
          check("t4 stall data", out_data, held);
          check("t4 stall valid", out_valid, 1'b1);
        end
        ready_mode = 0;
      end
    join
    wait_frames("t4", 1);
    append_expected(pay, 60);
    compare_stream("t4 stall");

    // Test 5: reset at payload byte 5, then a clean frame.
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'(8'hA0 + i));
    send(pay, 0, 5);
    rst = 1'b1;
    #1;
    check_outputs_zero("t5 rst early");
    @(posedge clk); @(posedge clk); #1;
    check_outputs_zero("t5 rst late");
    rst = 1'b0;
    rx_q.delete();
    frames_done = 0;
    @(posedge clk); #1;
    check("t5 idle after rst", a_out_valid, 1'b0);
    send(pay, 0, -1);
    wait_frames("t5", 1);
    append_expected(pay, 60);
    compare_stream("t5 after reset");

    // Test 6: 200 back-to-back random frames, random gaps and sink ready.
    ready_mode = 1;
    for (int f = 0; f < 200; f++) begin
      pay.delete();
      for (int i = 0, n = $urandom_range(200, 1); i < n; i++) pay.push_back(8'($urandom_range(255)));
      append_expected(pay, 60);
      send(pay, 30, -1);
    end
    wait_frames("t6", 200);
    compare_stream("t6 stream");
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
